// File: rtl/alu_seq_if.sv
// Request/response bundle between the control unit and the sequential ALU.
// The master drives the request; the slave (alu_seq) returns registered results.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       func;
    logic [WIDTH-1:0] res;
    logic             isZero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, func,
        input  res, isZero, hi, lo, busy, done
    );

    modport slave (
        input  start, a, b, func,
        output res, isZero, hi, lo, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// Registered MIPS32 ALU: single-cycle logic/compare ops plus iterative
// signed/unsigned multiply and divide writing the HI/LO registers.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_res, w_res_nxt;
    logic [WIDTH-1:0] r_hi, w_hi_nxt;
    logic [WIDTH-1:0] r_lo, w_lo_nxt;
    logic             r_is_zero, w_is_zero_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [CntW-1:0]  r_cnt, w_cnt_nxt;
    logic             r_is_div, w_is_div_nxt;
    logic             r_neg_q, w_neg_q_nxt;
    logic             r_neg_r, w_neg_r_nxt;
    logic             r_div0, w_div0_nxt;
    logic [WIDTH-1:0] r_mcand, w_mcand_nxt;
    logic [WIDTH-1:0] r_acc, w_acc_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;

    logic [WIDTH-1:0]   w_alu, w_mag_a, w_mag_b, w_quo, w_rem, w_lo_fix, w_hi_fix;
    logic               w_a_neg, w_b_neg, w_signed_op, w_multi;
    logic [WIDTH:0]     w_sum, w_shift, w_diff;
    logic [2*WIDTH-1:0] w_prod_mag, w_prod;

    always_comb begin
        w_alu = '0;
        case (bus.func)
            4'd0:    w_alu = bus.a + bus.b;
            4'd1:    w_alu = bus.a - bus.b;
            4'd2:    w_alu = bus.a & bus.b;
            4'd3:    w_alu = bus.a | bus.b;
            4'd4:    w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            4'd5:    w_alu = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            4'd6:    w_alu = bus.a ^ bus.b;
            4'd7:    w_alu = ~(bus.a | bus.b);
            4'd12:   w_alu = r_hi;
            4'd13:   w_alu = r_lo;
            default: w_alu = '0;
        endcase
    end

    // func 8..11 are multi-cycle; even codes (MULT, DIV) are the signed ones.
    assign w_multi     = (bus.func[3:2] == 2'b10);
    assign w_signed_op = w_multi & ~bus.func[0];
    assign w_a_neg     = w_signed_op & bus.a[WIDTH-1];
    assign w_b_neg     = w_signed_op & bus.b[WIDTH-1];
    assign w_mag_a     = w_a_neg ? -bus.a : bus.a;
    assign w_mag_b     = w_b_neg ? -bus.b : bus.b;

    // Multiply keeps {acc, q} as the partial product; divide keeps acc as the
    // partial remainder and shifts quotient bits into q.
    assign w_sum      = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_mcand} : '0);
    assign w_shift    = {r_acc, r_q[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_mcand};
    assign w_prod_mag = {r_acc, r_q};
    assign w_prod     = r_neg_q ? -w_prod_mag : w_prod_mag;
    assign w_quo      = r_neg_q ? -r_q : r_q;
    assign w_rem      = r_neg_r ? -r_acc : r_acc;
    assign w_lo_fix   = r_is_div ? (r_div0 ? '1 : w_quo) : w_prod[WIDTH-1:0];
    assign w_hi_fix   = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];

    always_comb begin
        w_state_nxt   = r_state;
        w_res_nxt     = r_res;
        w_is_zero_nxt = r_is_zero;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_cnt_nxt     = r_cnt;
        w_is_div_nxt  = r_is_div;
        w_neg_q_nxt   = r_neg_q;
        w_neg_r_nxt   = r_neg_r;
        w_div0_nxt    = r_div0;
        w_mcand_nxt   = r_mcand;
        w_acc_nxt     = r_acc;
        w_q_nxt       = r_q;
        case (r_state)
            StIdle: begin
                if (bus.start) begin
                    if (w_multi) begin
                        w_is_div_nxt = bus.func[1];
                        w_mcand_nxt  = bus.func[1] ? w_mag_b : w_mag_a;
                        w_q_nxt      = bus.func[1] ? w_mag_a : w_mag_b;
                        w_acc_nxt    = '0;
                        w_cnt_nxt    = '0;
                        w_neg_q_nxt  = w_a_neg ^ w_b_neg;
                        w_neg_r_nxt  = w_a_neg & bus.func[1];
                        w_div0_nxt   = bus.func[1] & (bus.b == '0);
                        w_busy_nxt   = 1'b1;
                        w_state_nxt  = StRun;
                    end else begin
                        w_res_nxt     = w_alu;
                        w_is_zero_nxt = (w_alu == '0);
                        w_done_nxt    = 1'b1;
                    end
                end
            end
            StRun: begin
                if (r_is_div) begin
                    // Dividing by zero leaves the dividend bits in acc; lo is forced in FIX.
                    if (!w_diff[WIDTH]) begin
                        w_acc_nxt = w_diff[WIDTH-1:0];
                        w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        w_acc_nxt = w_shift[WIDTH-1:0];
                        w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    w_acc_nxt = w_sum[WIDTH:1];
                    w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
                end
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LastCnt) w_state_nxt = StFix;
            end
            StFix: begin
                w_hi_nxt      = w_hi_fix;
                w_lo_nxt      = w_lo_fix;
                w_res_nxt     = w_lo_fix;
                w_is_zero_nxt = (w_lo_fix == '0);
                w_done_nxt    = 1'b1;
                w_busy_nxt    = 1'b0;
                w_state_nxt   = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_res     <= '0;
            r_is_zero <= 1'b1;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div0    <= 1'b0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_q       <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_res     <= w_res_nxt;
            r_is_zero <= w_is_zero_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_cnt     <= w_cnt_nxt;
            r_is_div  <= w_is_div_nxt;
            r_neg_q   <= w_neg_q_nxt;
            r_neg_r   <= w_neg_r_nxt;
            r_div0    <= w_div0_nxt;
            r_mcand   <= w_mcand_nxt;
            r_acc     <= w_acc_nxt;
            r_q       <= w_q_nxt;
        end
    end

    assign bus.res    = r_res;
    assign bus.isZero = r_is_zero;
    assign bus.hi     = r_hi;
    assign bus.lo     = r_lo;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a behavioural model queues expected results at
// issue time and a monitor retires them on each done pulse.
module tb_alu_seq;
    logic clk;
    logic rst;

    alu_seq_if #(.WIDTH(32)) bus ();
    alu_seq_if #(.WIDTH(8))  bus8 ();

    alu_seq #(.WIDTH(32)) u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
    alu_seq #(.WIDTH(8))  u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_ops   = 0;
    logic [31:0] m_res   = '0;
    logic [31:0] m_hi    = '0;
    logic [31:0] m_lo    = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [3:0] f, input logic [31:0] a,
                                  input logic [31:0] b, output exp_t e);
        longint      sa, sb_, q, rm;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        r = '0;
        case (f)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd5: r = (a < b) ? 32'd1 : 32'd0;
            4'd6: r = a ^ b;
            4'd7: r = ~(a | b);
            4'd8: begin p = 64'(sa * sb_); m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; end
            4'd9: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; end
            4'd10: begin
                if (b == 32'd0) begin
                    m_lo = '1; m_hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = a; m_hi = '0;
                end else begin
                    q = sa / sb_; rm = sa % sb_;
                    m_lo = q[31:0]; m_hi = rm[31:0];
                end
                r = m_lo;
            end
            4'd11: begin
                if (b == 32'd0) begin
                    m_lo = '1; m_hi = a;
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
                r = m_lo;
            end
            4'd12: r = m_hi;
            4'd13: r = m_lo;
            default: r = '0;
        endcase
        m_res = r;
        e.tag = $sformatf("op%0d_f%0d", n_ops, f);
        e.res = r;
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.lat = (f inside {[8:11]}) ? 34 : 1;
        n_ops++;
    endfunction

    // Retire one expectation per done pulse.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq({e.tag, "_res"}, bus.res, e.res);
                check_eq({e.tag, "_iszero"}, bus.isZero, (e.res == 32'd0));
                check_eq({e.tag, "_hi"}, bus.hi, e.hi);
                check_eq({e.tag, "_lo"}, bus.lo, e.lo);
            end
        end
    end

    task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit probe);
        exp_t        e;
        int          lat;
        logic [31:0] o_res, o_hi, o_lo;
        o_res = m_res;
        o_hi  = m_hi;
        o_lo  = m_lo;
        model(f, a, b, e);
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b1; bus.func = f; bus.a = a; bus.b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 1;
        if (e.lat > 1) check_eq({e.tag, "_busy1"}, bus.busy, 1'b1);
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (probe && lat == 5) begin
                bus.start = 1'b1; bus.func = 4'd0; bus.a = 32'd11; bus.b = 32'd22;
            end
            if (probe && lat == 6) bus.start = 1'b0;
            if (probe && lat == 8) begin
                check_eq({e.tag, "_busy_res_hold"}, bus.res, o_res);
                check_eq({e.tag, "_busy_hi_hold"}, bus.hi, o_hi);
                check_eq({e.tag, "_busy_lo_hold"}, bus.lo, o_lo);
            end
        end
        check_eq({e.tag, "_lat"}, lat, e.lat);
        check_eq({e.tag, "_busy_at_done"}, bus.busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_res"}, bus.res, 32'd0);
        check_eq({tag, "_iszero"}, bus.isZero, 1'b1);
        check_eq({tag, "_hi"}, bus.hi, 32'd0);
        check_eq({tag, "_lo"}, bus.lo, 32'd0);
        check_eq({tag, "_busy"}, bus.busy, 1'b0);
        check_eq({tag, "_done"}, bus.done, 1'b0);
    endtask

    task automatic run8(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ehi, input logic [7:0] elo, input string tag);
        int lat;
        @(negedge clk);
        bus8.start = 1'b1; bus8.func = f; bus8.a = a; bus8.b = b;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        lat = 1;
        while (!bus8.done && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_lat"}, lat, 10);
        check_eq({tag, "_hi"}, bus8.hi, ehi);
        check_eq({tag, "_lo"}, bus8.lo, elo);
        check_eq({tag, "_res"}, bus8.res, elo);
    endtask

    initial begin
        int          ndone;
        logic [3:0]  rf;
        logic [31:0] ra, rb;
        rst = 1'b1;
        bus.start = 1'b0; bus.func = '0; bus.a = '0; bus.b = '0;
        bus8.start = 1'b0; bus8.func = '0; bus8.a = '0; bus8.b = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("idle");

        issue(4'd0, 32'h7FFF_FFFF, 32'd1, 1'b0);
        issue(4'd1, 32'd5, 32'd5, 1'b0);
        issue(4'd4, 32'hFFFF_FFFF, 32'd1, 1'b0);
        issue(4'd5, 32'hFFFF_FFFF, 32'd1, 1'b0);
        issue(4'd7, 32'd0, 32'd0, 1'b0);
        issue(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
        issue(4'd3, 32'hF000_0001, 32'h000F_0010, 1'b0);
        issue(4'd6, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0);
        issue(4'd8, 32'hFFFF_FFFD, 32'd7, 1'b0);
        issue(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue(4'd12, 32'd0, 32'd0, 1'b0);
        issue(4'd13, 32'd0, 32'd0, 1'b0);
        issue(4'd10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        issue(4'd11, 32'd100, 32'd0, 1'b0);
        issue(4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        issue(4'd10, 32'hFFFF_FFF9, 32'd0, 1'b0);
        issue(4'd14, 32'd3, 32'd4, 1'b0);
        issue(4'd12, 32'd0, 32'd0, 1'b0);
        issue(4'd8, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);

        for (int i = 0; i < 24; i++) begin
            rf = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = (i % 6 == 5) ? 32'd0 : ((i % 2 == 1) ? $urandom_range(1, 300) : $urandom);
            if (i % 5 == 4) ra = -ra;
            issue(rf, ra, rb, 1'b0);
        end

        // Async reset in cycle 10 of a DIVU: outputs clear and the op never completes.
        @(negedge clk);
        bus.start = 1'b1; bus.func = 4'd11; bus.a = 32'd1000; bus.b = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid_divu");
        m_res = '0; m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check_eq("rst_mid_divu_no_done", ndone, 0);

        issue(4'd13, 32'd0, 32'd0, 1'b0);
        issue(4'd11, 32'd1000, 32'd7, 1'b0);

        run8(4'd8, 8'h80, 8'h80, 8'h40, 8'h00, "w8_mult");
        run8(4'd10, 8'hF9, 8'h02, 8'hFF, 8'hFD, "w8_div");

        repeat (3) @(negedge clk);
        check_eq("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the single-cycle datapath ALU for the MIPS32 SoC. It adds iterative multiply and divide (signed and unsigned) with HI/LO result registers and a start/busy/done handshake. Single-cycle logic and compare operations complete one cycle after start. The control unit stalls the pipeline while `busy` is high and reads HI/LO through `MFHI`/`MFLO` operations.

## Interface
- `WIDTH`, default 32, operand/result width (≥4, even).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; `a`, `b`, `func` sampled on the same edge.
- `a`  in  WIDTH  operand A (dividend / multiplicand).
- `b`  in  WIDTH  operand B (divisor / multiplier).
- `func`  in  4  operation code:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLTU, 6 XOR, 7 NOR
  - 8 MULT, 9 MULTU, 10 DIV, 11 DIVU, 12 MFHI, 13 MFLO
  - 14–15 reserved
- `res`  out  WIDTH  registered result.
- `isZero`  out  1  registered, equals (`res` == 0).
- `hi`  out  WIDTH  HI register: product upper half / remainder.
- `lo`  out  WIDTH  LO register: product lower half / quotient.
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  one-cycle pulse: `res` updated this cycle.

## Operation
- FSM states IDLE, RUN, FIX.
- Reset values: state IDLE, `res`=0, `isZero`=1, `hi`=`lo`=0, `busy`=0, `done`=0, iteration counter 0.
- **IDLE, `start`=1, func 0–7, 12, 13:**
  - `res` loads the function result; state stays IDLE; `done`=1 next cycle.
  - SLT is a signed compare and SLTU an unsigned compare; the result is zero-extended 0/1.
  - Arithmetic wraps modulo 2^WIDTH.
  - MFHI/MFLO copy the current `hi`/`lo`.
- **Reserved func:** `res`=0, `done` pulses, `hi`/`lo` unchanged.
- **IDLE, `start`=1, func 8–11:**
  - Latch operand magnitudes (absolute value for signed ops; 2^(WIDTH−1) magnitude is representable as unsigned).
  - Latch the result sign flags.
  - Clear the counter and go to RUN with `busy`=1.
- **RUN:**
  - One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
  - Exactly WIDTH cycles, then FIX.
- **FIX:**
  - Apply sign correction: product negated if operand signs differ; quotient negated if signs differ; remainder takes the dividend's sign; division truncates toward zero.
  - Write `hi`/`lo`, set `res`=`lo`, pulse `done`, clear `busy`, return to IDLE.
- **Divide by zero (DIV/DIVU):** `lo`=all ones, `hi`=`a`, no exception.
- **DIV of most-negative by −1:** `lo`=most-negative, `hi`=0.
- **`start` while `busy`:** ignored. No queueing, and `hi`/`lo` are unaffected.
- **Register holds:**
  - `hi`/`lo` change only in FIX.
  - `res` changes only on an accepted single-cycle op or in FIX.
- **`rst` mid-operation:** abort immediately to reset values; no `done` pulse.

## Timing
- `start` is sampled in cycle 0 (edge E0).
- Single-cycle ops: `res`/`isZero`/`done` valid in cycle 1. A back-to-back `start` every cycle is legal.
- Multi-cycle ops:
  - `busy`=1 in cycles 1..WIDTH+1.
  - `done`=1 and `hi`/`lo`/`res` valid in cycle WIDTH+2 (34 for WIDTH=32), with `busy`=0 in that cycle.
  - A new `start` is accepted in cycle WIDTH+2.
- `done` is never high for two consecutive cycles from a single start.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Test plan
- Reset then idle: all outputs at reset values; ADD 0x7FFFFFFF+1 → `res`=0x80000000, `isZero`=0, `done` in cycle 1. SUB 5−5 → `res`=0, `isZero`=1.
- Compares: SLT a=0xFFFFFFFF, b=1 → `res`=1; SLTU same operands → `res`=0. NOR 0,0 → 0xFFFFFFFF.
- MULT a=−3 (0xFFFFFFFD), b=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `done` in cycle 34. MULTU 0xFFFFFFFF×0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=1. MFHI afterwards → `res`=0xFFFFFFFE.
- DIV a=−7, b=2 → `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1). DIVU 100/0 → `lo`=0xFFFFFFFF, `hi`=100. DIV 0x80000000/−1 → `lo`=0x80000000, `hi`=0.
- Handshake:
  - `start` ADD while `busy` → ignored, with `res`/`hi`/`lo` unchanged until FIX.
  - `rst` asserted in cycle 10 of DIVU → all outputs reset asynchronously and no `done` follows.
- WIDTH=8 instance: MULT 0x80×0x80 → `hi`=0x40, `lo`=0x00, `done` in cycle 10.
